// File: rtl/flowctl_pkg.sv
// Shared FlowControl definitions: FSM encoding and width helper.
package flowctl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STEP     = 2'd1,
        WAIT_LOW = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int r;
        int x;
        r = 0;
        x = value - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester select, searching upward from ptr+1.
module rr_arbiter
    import flowctl_pkg::*;
#(
    parameter  int M   = 4,
    localparam int IDW = clog2(M)
) (
    input  logic [M-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           valid,
    output logic [IDW-1:0] sel,
    output logic [M-1:0]   onehot
);

    logic [IDW-1:0] idx;

    always_comb begin
        valid  = 1'b0;
        sel    = '0;
        onehot = '0;
        idx    = '0;
        for (int i = 1; i <= M; i++) begin
            idx = IDW'((int'(ptr) + i) % M);
            if (!valid && req[idx]) begin
                valid = 1'b1;
                sel   = idx;
            end
        end
        if (valid) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/step_counter_arbiter.sv
// Shared thermometer loop counter stepped by M 4-phase requesters.
module step_counter_arbiter
    import flowctl_pkg::*;
#(
    parameter  int N   = 10,
    parameter  int M   = 4,
    localparam int IDW = clog2(M)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [M-1:0]   addReq,
    output logic [M-1:0]   addFin,
    input  logic           clr,
    output logic [N-1:0]   count,
    output logic           fin,
    output logic [IDW-1:0] finId,
    output logic [M-1:0]   grant,
    output logic           busy
);

    state_e         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [M-1:0]   grant_q, grant_d;
    logic [M-1:0]   add_fin_q, add_fin_d;
    logic [N-1:0]   count_q, count_d;
    logic           fin_q, fin_d;
    logic [IDW-1:0] fin_id_q, fin_id_d;

    logic           arb_valid;
    logic [IDW-1:0] arb_sel;
    logic [M-1:0]   arb_onehot;

    rr_arbiter #(.M(M)) u_arb (
        .req    (addReq),
        .ptr    (ptr_q),
        .valid  (arb_valid),
        .sel    (arb_sel),
        .onehot (arb_onehot)
    );

    // ptr_q doubles as the current owner index once a grant is issued
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        add_fin_d = add_fin_q;
        count_d   = count_q;
        fin_d     = 1'b0;
        fin_id_d  = '0;
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_onehot;
                    ptr_d   = arb_sel;
                    state_d = STEP;
                end
            end
            STEP: begin
                add_fin_d = grant_q;
                state_d   = WAIT_LOW;
                if (count_q[N-2]) begin
                    count_d  = N'(1);
                    fin_d    = 1'b1;
                    fin_id_d = ptr_q;
                end else begin
                    count_d = {count_q[N-2:0], 1'b1};
                end
            end
            WAIT_LOW: begin
                if (!addReq[ptr_q]) begin
                    add_fin_d = '0;
                    grant_d   = '0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // clear wins on the counter but never swallows an acknowledge
        if (clr) begin
            count_d  = N'(1);
            fin_d    = 1'b0;
            fin_id_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= IDW'(M - 1);
            grant_q   <= '0;
            add_fin_q <= '0;
            count_q   <= N'(1);
            fin_q     <= 1'b0;
            fin_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            add_fin_q <= add_fin_d;
            count_q   <= count_d;
            fin_q     <= fin_d;
            fin_id_q  <= fin_id_d;
        end
    end

    assign addFin = add_fin_q;
    assign grant  = grant_q;
    assign count  = count_q;
    assign fin    = fin_q;
    assign finId  = fin_id_q;
    assign busy   = (state_q != IDLE);

endmodule
